// File: rtl/line_unpack_buffer.sv
// ---------------------------------------------------------------------------
// line_unpack_buffer
//
// Stores wide memory lines and hands them out as WIDTH-bit elements in a
// first-word-fall-through stream. Each line has its own [base, bound)
// element window, so partial first/last lines of a range are trimmed here.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   wrreq          line write request (accepted when wrreq && !full)
//   wdata          line data, FULL_WIDTH bits
//   wbase          first element index to emit (inclusive)
//   wbound         end element index (exclusive), clamped to MAX_ELEMS
//   wlast          line is the final line of its transfer
//   full           every line slot is occupied
//   wdrop          one-cycle pulse: accepted line had an empty window
//   rdreq          pop the current element (ignored while empty)
//   empty          no element available
//   rdata          current element
//   rline_end      current element is the last of its line
//   rlast          current element is the last of a wlast line
//   count          total elements currently buffered
// ---------------------------------------------------------------------------
module line_unpack_buffer #(
  parameter int FULL_WIDTH = 512,
  parameter int WIDTH      = 64,
  parameter int LOG_DEPTH  = 4,
  parameter int MSB_FIRST  = 1,
  localparam int MAX_ELEMS = FULL_WIDTH / WIDTH,
  localparam int IDX_W     = $clog2(MAX_ELEMS) + 1,
  localparam int CNT_W     = LOG_DEPTH + IDX_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wrreq,
  input  logic [FULL_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      wbase,
  input  logic [IDX_W-1:0]      wbound,
  input  logic                  wlast,
  output logic                  full,
  output logic                  wdrop,
  input  logic                  rdreq,
  output logic                  empty,
  output logic [WIDTH-1:0]      rdata,
  output logic                  rline_end,
  output logic                  rlast,
  output logic [CNT_W-1:0]      count
);

  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam int SEL_W = (MAX_ELEMS > 1) ? $clog2(MAX_ELEMS) : 1;
  localparam logic [IDX_W-1:0]   MAX_IDX    = IDX_W'(MAX_ELEMS);
  localparam logic [LOG_DEPTH:0] FULL_LINES = (LOG_DEPTH + 1)'(DEPTH);
  localparam logic [LOG_DEPTH:0] ONE_LINE   = (LOG_DEPTH + 1)'(1);

  // Line storage (no reset: contents are don't-care until written)
  logic [FULL_WIDTH-1:0] r_data [DEPTH];
  logic [IDX_W-1:0]      r_base [DEPTH];
  logic [IDX_W-1:0]      r_end  [DEPTH];
  logic [DEPTH-1:0]      r_last;

  // Control state
  logic [LOG_DEPTH:0]   r_lines;
  logic [LOG_DEPTH-1:0] r_wrline;
  logic [LOG_DEPTH-1:0] r_rdline;
  logic [IDX_W-1:0]     r_rdptr;
  logic [CNT_W-1:0]     r_count;
  logic                 r_wdrop;

  logic [IDX_W-1:0]      w_eb;
  logic [IDX_W-1:0]      w_win;
  logic                  w_win_ok;
  logic                  w_wr_take;
  logic                  w_accept;
  logic                  w_drop;
  logic                  w_pop;
  logic                  w_at_end;
  logic                  w_pop_end;
  logic [IDX_W-1:0]      w_head_end;
  logic [LOG_DEPTH-1:0]  w_next_rdline;
  logic [IDX_W-1:0]      w_rdptr_nxt;
  logic [LOG_DEPTH:0]    w_lines_nxt;
  logic [CNT_W-1:0]      w_count_nxt;
  logic [FULL_WIDTH-1:0] w_head_data;
  logic [WIDTH-1:0]      w_elems [MAX_ELEMS];

  // full is taken from the registered line count only, so a slot freed in
  // the same cycle cannot be reused by a concurrent write.
  assign full  = (r_lines == FULL_LINES);
  assign empty = (r_lines == {(LOG_DEPTH + 1){1'b0}});

  // Write window: clamp the bound, then decide keep or drop
  always_comb begin
    if (wbound > MAX_IDX) begin
      w_eb = MAX_IDX;
    end else begin
      w_eb = wbound;
    end
  end

  assign w_win     = w_eb - wbase;
  assign w_win_ok  = (wbase < w_eb);
  assign w_wr_take = wrreq && !full;
  assign w_accept  = w_wr_take && w_win_ok;
  assign w_drop    = w_wr_take && !w_win_ok;

  // Read side
  assign w_head_end    = r_end[r_rdline];
  assign w_at_end      = (r_rdptr == (w_head_end - IDX_W'(1)));
  assign w_pop         = rdreq && !empty;
  assign w_pop_end     = w_pop && w_at_end;
  assign w_next_rdline = r_rdline + LOG_DEPTH'(1);

  // Element pointer: reload with the new head's base whenever a line
  // becomes head; if that line is being written this very cycle its base
  // is still on wbase rather than in storage.
  always_comb begin
    w_rdptr_nxt = r_rdptr;
    if (w_pop_end) begin
      if (r_lines == ONE_LINE) begin
        if (w_accept) begin
          w_rdptr_nxt = wbase;
        end else begin
          w_rdptr_nxt = r_rdptr;
        end
      end else begin
        w_rdptr_nxt = r_base[w_next_rdline];
      end
    end else if (w_pop) begin
      w_rdptr_nxt = r_rdptr + IDX_W'(1);
    end else if (empty && w_accept) begin
      w_rdptr_nxt = wbase;
    end else begin
      w_rdptr_nxt = r_rdptr;
    end
  end

  // Line and element counters: write and pop deltas apply independently
  always_comb begin
    w_lines_nxt = r_lines + (LOG_DEPTH + 1)'(w_accept) - (LOG_DEPTH + 1)'(w_pop_end);
    w_count_nxt = r_count;
    if (w_accept) begin
      w_count_nxt = w_count_nxt + CNT_W'(w_win);
    end else begin
      w_count_nxt = w_count_nxt;
    end
    if (w_pop) begin
      w_count_nxt = w_count_nxt - CNT_W'(1);
    end else begin
      w_count_nxt = w_count_nxt;
    end
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lines  <= '0;
      r_wrline <= '0;
      r_rdline <= '0;
      r_rdptr  <= '0;
      r_count  <= '0;
      r_wdrop  <= 1'b0;
    end else begin
      r_lines <= w_lines_nxt;
      r_rdptr <= w_rdptr_nxt;
      r_count <= w_count_nxt;
      r_wdrop <= w_drop;
      if (w_accept) begin
        r_wrline <= r_wrline + LOG_DEPTH'(1);
      end
      if (w_pop_end) begin
        r_rdline <= w_next_rdline;
      end
    end
  end

  // Line slot write
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_data[r_wrline] <= wdata;
      r_base[r_wrline] <= wbase;
      r_end[r_wrline]  <= w_eb;
      r_last[r_wrline] <= wlast;
    end
  end

  // Split the head line into elements in the configured order
  assign w_head_data = r_data[r_rdline];

  genvar gi;
  generate
    for (gi = 0; gi < MAX_ELEMS; gi++) begin : g_elem
      if (MSB_FIRST != 0) begin : g_msb
        assign w_elems[gi] = w_head_data[FULL_WIDTH-1-gi*WIDTH -: WIDTH];
      end else begin : g_lsb
        assign w_elems[gi] = w_head_data[gi*WIDTH +: WIDTH];
      end
    end
  endgenerate

  assign rdata     = w_elems[r_rdptr[SEL_W-1:0]];
  assign rline_end = !empty && w_at_end;
  assign rlast     = rline_end && r_last[r_rdline];
  assign count     = r_count;
  assign wdrop     = r_wdrop;

endmodule

// File: tb/tb_line_unpack_buffer.sv
module tb_line_unpack_buffer;

  logic         clk = 1'b0;
  logic         rst;
  logic         wrreq, wlast, rdreq;
  logic [511:0] wdata;
  logic [3:0]   wbase, wbound;
  logic         full, wdrop, empty, rline_end, rlast;
  logic [63:0]  rdata;
  logic [5:0]   count;

  logic         b_wrreq, b_wlast, b_rdreq;
  logic [511:0] b_wdata;
  logic [3:0]   b_wbase, b_wbound;
  logic         b_full, b_wdrop, b_empty, b_rline_end, b_rlast;
  logic [63:0]  b_rdata;
  logic [5:0]   b_count;

  line_unpack_buffer #(.FULL_WIDTH(512), .WIDTH(64), .LOG_DEPTH(2), .MSB_FIRST(1)) u_dut (
    .clk(clk), .rst(rst), .wrreq(wrreq), .wdata(wdata), .wbase(wbase),
    .wbound(wbound), .wlast(wlast), .full(full), .wdrop(wdrop),
    .rdreq(rdreq), .empty(empty), .rdata(rdata), .rline_end(rline_end),
    .rlast(rlast), .count(count)
  );

  line_unpack_buffer #(.FULL_WIDTH(512), .WIDTH(64), .LOG_DEPTH(2), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .wrreq(b_wrreq), .wdata(b_wdata), .wbase(b_wbase),
    .wbound(b_wbound), .wlast(b_wlast), .full(b_full), .wdrop(b_wdrop),
    .rdreq(b_rdreq), .empty(b_empty), .rdata(b_rdata), .rline_end(b_rline_end),
    .rlast(b_rlast), .count(b_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] d;
    logic        le;
    logic        la;
  } exp_t;

  exp_t q[$];
  int   m_lines = 0;
  int   m_count = 0;
  int   checks  = 0;
  int   passes  = 0;
  int   fails   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line whose element i (MSB-first) holds tag+i
  function automatic logic [511:0] mk_line(input logic [63:0] tag);
    logic [511:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      v[511-64*i -: 64] = tag + 64'(i);
    end
    return v;
  endfunction

  // Scoreboard model of one write attempt against pre-edge state; returns drop
  function automatic bit model_write(input logic [63:0] tag, input int base,
                                     input int bound, input bit last);
    int eb;
    if (m_lines == 4) return 1'b0;
    eb = (bound > 8) ? 8 : bound;
    if (base >= eb) return 1'b1;
    for (int e = base; e < eb; e++) begin
      q.push_back({tag + 64'(e), (e == eb - 1), (last && (e == eb - 1))});
    end
    m_lines++;
    m_count += eb - base;
    return 1'b0;
  endfunction

  task automatic drive_wr(input logic [63:0] tag, input int base, input int bound, input bit last);
    wdata  = mk_line(tag);
    wbase  = 4'(base);
    wbound = 4'(bound);
    wlast  = last;
    wrreq  = 1'b1;
  endtask

  task automatic wr(input logic [63:0] tag, input int base, input int bound, input bit last);
    bit drop;
    chk("wr_full", full, (m_lines == 4));
    drive_wr(tag, base, bound, last);
    drop = model_write(tag, base, bound, last);
    tick();
    wrreq = 1'b0;
    chk("wdrop", wdrop, drop);
    chk("wr_count", count, 64'(m_count));
  endtask

  // Check the head element against the scoreboard, then pop it, optionally
  // writing a line in the same cycle.
  task automatic pop(input bit do_wr, input logic [63:0] tag, input int base,
                     input int bound, input bit last);
    exp_t ent;
    bit   drop;
    chk("empty", empty, (q.size() == 0));
    if (q.size() == 0) return;
    ent = q.pop_front();
    chk("rdata", rdata, ent.d);
    chk("rline_end", rline_end, ent.le);
    chk("rlast", rlast, ent.la);
    chk("count", count, 64'(m_count));
    if (do_wr) begin
      chk("pw_full", full, (m_lines == 4));
      drive_wr(tag, base, bound, last);
      drop = model_write(tag, base, bound, last);
    end
    if (ent.le) m_lines--;
    m_count--;
    rdreq = 1'b1;
    tick();
    rdreq = 1'b0;
    wrreq = 1'b0;
  endtask

  initial begin
    logic [511:0] lsb_line;
    rst = 1'b1; wrreq = 1'b0; rdreq = 1'b0; wlast = 1'b0;
    wdata = '0; wbase = '0; wbound = '0;
    b_wrreq = 1'b0; b_rdreq = 1'b0; b_wlast = 1'b0;
    b_wdata = '0; b_wbase = '0; b_wbound = '0;
    tick();
    tick();
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_count", count, 64'd0);
    chk("rst_line_end", rline_end, 1'b0);
    chk("rst_rlast", rlast, 1'b0);
    chk("rst_wdrop", wdrop, 1'b0);
    rst = 1'b0;
    tick();

    // Full window, MSB-first elements 0..7
    wr(64'd0, 0, 8, 1'b1);
    chk("lat_empty", empty, 1'b0);
    for (int i = 0; i < 8; i++) pop(1'b0, 64'd0, 0, 0, 1'b0);
    chk("t1_empty", empty, 1'b1);
    chk("t1_count", count, 64'd0);

    // Trimmed window, then clamped bound
    wr(64'd0, 3, 5, 1'b0);
    for (int i = 0; i < 2; i++) pop(1'b0, 64'd0, 0, 0, 1'b0);
    chk("t2_count", count, 64'd0);
    wr(64'd0, 3, 12, 1'b1);
    chk("clamp_count", count, 64'd5);
    for (int i = 0; i < 5; i++) pop(1'b0, 64'd0, 0, 0, 1'b0);
    chk("t3_empty", empty, 1'b1);

    // Empty window is dropped
    wr(64'd0, 5, 5, 1'b1);
    chk("drop_empty", empty, 1'b1);
    chk("drop_full", full, 1'b0);
    tick();
    chk("drop_pulse_end", wdrop, 1'b0);

    // Fill all slots, then write while popping the last element of line 0
    wr(64'd16, 0, 8, 1'b0);
    wr(64'd32, 0, 8, 1'b0);
    wr(64'd48, 0, 8, 1'b0);
    wr(64'd64, 0, 8, 1'b1);
    chk("fill_full", full, 1'b1);
    for (int i = 0; i < 7; i++) pop(1'b0, 64'd0, 0, 0, 1'b0);
    pop(1'b1, 64'd80, 0, 8, 1'b0);
    chk("post_full", full, 1'b0);
    chk("no_bubble_empty", empty, 1'b0);
    chk("no_bubble_rdata", rdata, 64'd32);
    chk("post_count", count, 64'd24);
    pop(1'b0, 64'd0, 0, 0, 1'b0);
    pop(1'b0, 64'd0, 0, 0, 1'b0);

    // Asynchronous reset mid-line with 3 lines buffered
    #2;
    rst = 1'b1;
    #1;
    chk("arst_empty", empty, 1'b1);
    chk("arst_count", count, 64'd0);
    chk("arst_line_end", rline_end, 1'b0);
    q.delete();
    m_lines = 0;
    m_count = 0;
    tick();
    rst = 1'b0;
    tick();
    wr(64'd96, 2, 6, 1'b1);
    for (int i = 0; i < 4; i++) pop(1'b0, 64'd0, 0, 0, 1'b0);
    chk("post_rst_empty", empty, 1'b1);

    // Line handover where the next head is written in the same cycle
    wr(64'd112, 6, 8, 1'b0);
    pop(1'b0, 64'd0, 0, 0, 1'b0);
    pop(1'b1, 64'd128, 1, 3, 1'b1);
    pop(1'b0, 64'd0, 0, 0, 1'b0);
    pop(1'b0, 64'd0, 0, 0, 1'b0);
    chk("handover_empty", empty, 1'b1);
    chk("handover_count", count, 64'd0);

    // LSB-first instance
    lsb_line = '0;
    lsb_line[63:0]   = 64'hA;
    lsb_line[127:64] = 64'hB;
    b_wdata  = lsb_line;
    b_wbase  = 4'd0;
    b_wbound = 4'd2;
    b_wlast  = 1'b1;
    b_wrreq  = 1'b1;
    tick();
    b_wrreq = 1'b0;
    chk("lsb_count", b_count, 64'd2);
    chk("lsb_rdata0", b_rdata, 64'hA);
    chk("lsb_end0", b_rline_end, 1'b0);
    b_rdreq = 1'b1;
    tick();
    b_rdreq = 1'b0;
    chk("lsb_rdata1", b_rdata, 64'hB);
    chk("lsb_last1", b_rlast, 1'b1);
    b_rdreq = 1'b1;
    tick();
    b_rdreq = 1'b0;
    chk("lsb_empty", b_empty, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/line_unpack_buffer.md
Name: line_unpack_buffer

Overview:
- Successor to the single-mode line read buffer in the pagerank memory path.
- Accepts wide memory lines (FULL_WIDTH bits) and returns them as WIDTH-bit elements in a first-word-fall-through stream.
- Each line carries its own [base, bound) element window, so partial first and last lines of an edge or vertex range are trimmed without software help.
- Adds configurable element order, an element-count output, line-end/last tagging, and explicit drop reporting for empty windows.

Parameters:
- FULL_WIDTH, 512: line width in bits; must be a multiple of WIDTH.
- WIDTH, 64: element width in bits.
- LOG_DEPTH, 4: line storage is 2**LOG_DEPTH lines.
- MSB_FIRST, 1: 1 means element 0 is wdata[FULL_WIDTH-1 -: WIDTH]; 0 means element 0 is wdata[WIDTH-1:0].
- Derived MAX_ELEMS = FULL_WIDTH/WIDTH.
- Derived IDX_W = $clog2(MAX_ELEMS)+1.
- Derived CNT_W = LOG_DEPTH+IDX_W.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- wrreq  in  1  line write request; accepted when wrreq && !full
- wdata  in  FULL_WIDTH  line data
- wbase  in  IDX_W  first element index to emit (inclusive)
- wbound  in  IDX_W  end element index (exclusive); values > MAX_ELEMS are clamped to MAX_ELEMS
- wlast  in  1  line is the final line of the current transfer
- full  out  1  all 2**LOG_DEPTH line slots occupied
- wdrop  out  1  one-cycle pulse: an accepted line had an empty window and was discarded
- rdreq  in  1  pop current element; effective only when !empty
- empty  out  1  no element available
- rdata  out  WIDTH  current element (valid while !empty)
- rline_end  out  1  current element is the last element of its line
- rlast  out  1  current element is the last element of a line written with wlast=1
- count  out  CNT_W  total elements currently buffered

Behaviour:
- Reset (async, rst=1): line count, write/read line pointers, element pointer and count go to 0; wdrop=0, full=0, empty=1; rline_end, rlast and count read 0. Storage contents are undefined. Reset mid-transfer discards all buffered lines.
- Per line slot, store: data, start index, clamped end index, last flag.
- Read element pointer: loaded with the line's base whenever that line becomes head.
- Write accept:
  - eb = min(wbound, MAX_ELEMS).
  - If wbase >= eb: no slot is consumed, wdrop pulses the next cycle, and the line's wlast is lost (the caller must not rely on it).
  - Otherwise the line occupies slot wrline, wrline increments (wraps modulo depth), and line count increments.
- Write-to-read latency: a line written into an empty buffer makes empty=0 on the following cycle, with rdata = element wbase.
- Output is combinational from head slot[rdptr]. rdata is unchanged while rdreq=0.
- Pop when rdptr == head end-1:
  - The head slot is freed and rdline increments.
  - rdptr loads the next slot's base in the same cycle.
  - No bubble between lines when the next line is already stored.
- Pop otherwise: rdptr increments.
- Simultaneous pop and write:
  - Both take effect and line count is unchanged if the pop frees a slot.
  - full is evaluated on the registered line count only: a write while full is rejected even if the same cycle frees a slot. No bypass.
  - A write into an empty buffer is never visible in the same cycle.
- count:
  - Write adds (eb - wbase).
  - Pop subtracts 1.
  - Both together apply both deltas.
  - count equals the sum of the remaining windows at all times.
- rline_end = !empty && rdptr == head end-1.
- rlast = rline_end && head last flag.
- rdreq while empty is ignored: no state change and no error.
- Pointer wrap: rdline and wrline are LOG_DEPTH bits. full = (lines == 2**LOG_DEPTH). empty = (lines == 0).

Test Plan:
- Defaults with LOG_DEPTH=2, MSB_FIRST=1. Write one line with data = elements 0..7 holding 64'h0..64'h7 in MSB-first order, base=0, bound=8, last=1; pop 8 times -> rdata = 0,1,...,7. rline_end and rlast are high only on element 7. empty=1 afterwards and count goes 8 -> 0.
- Same data with base=3, bound=5; pop -> rdata = 3 then 4 and count = 2 -> 1 -> 0. With bound=12 -> clamped, emits 3..7 (count=5).
- Write base=5, bound=5 -> wdrop=1 for one cycle, empty stays 1, count=0, and full is unaffected.
- Write 4 lines with base=0, bound=8 -> full=1. A 5th write, with a simultaneous pop of the final element of line 0, is rejected. After that cycle full=0, and rdata = line1 element 0 with no bubble.
- Assert rst for one cycle with 3 lines buffered mid-line -> empty=1 and count=0 immediately (async). The next written line starts cleanly at its own base.
- MSB_FIRST=0, wdata[63:0]=64'hA, wdata[127:64]=64'hB, base=0, bound=2 -> rdata = 64'hA then 64'hB.
